// File: rtl/seg7_capture.sv
// Readback monitor for a multiplexed active-low 7-segment display: recovers one nibble per digit
// and publishes a frame once all digits are seen. Optional macro SEG7_CAPTURE_BLANK_EN accepts 7F as a legal blank.
//
// state  | meaning
// SETTLE | waiting for {an,seg} to hold for STABLE_CYC samples; captures on arrival
// HOLD   | pattern already captured; waits for the next change
module seg7_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid
);

  localparam int         W       = DIGITS + 7;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYC - 2);
`ifdef SEG7_CAPTURE_BLANK_EN
  localparam logic BLANK_ERR = 1'b0;
`else
  localparam logic BLANK_ERR = 1'b1;
`endif

  typedef enum logic {SETTLE, HOLD} state_t;

  state_t                state, state_nxt;
  logic [W-1:0]          sync1, s, p;
  logic [7:0]            cnt;
  logic                  same, at_cap, capture, complete;
  logic [DIGITS-1:0]     sel, seen, slot_err;
  logic [4*DIGITS-1:0]   slot_val;
  logic [4:0]            dec;

  // {err, nibble}; illegal glyphs decode to nibble 0
  function automatic logic [4:0] decode(input logic [6:0] g);
    case (g)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h10: decode = 5'h09;
      7'h08: decode = 5'h0A;
      7'h03: decode = 5'h0B;
      7'h46: decode = 5'h0C;
      7'h21: decode = 5'h0D;
      7'h06: decode = 5'h0E;
      7'h0E: decode = 5'h0F;
      7'h7F: decode = {BLANK_ERR, 4'h0};
      default: decode = 5'h10;
    endcase
  endfunction

  // Synchronizer resets to all ones so the dark display looks stable from the start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      s     <= '1;
      p     <= '1;
    end else begin
      sync1 <= {an, seg};
      s     <= sync1;
      p     <= s;
    end
  end

  assign same   = (s == p);
  assign at_cap = same && (cnt == CNT_CAP);
  assign sel    = ~s[W-1:7];
  assign dec    = decode(s[6:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (!same)          cnt <= '0;
    else if (cnt < CNT_MAX)  cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SETTLE: if (at_cap) state_nxt = HOLD;
      HOLD:   if (!same)  state_nxt = SETTLE;
      default:            state_nxt = SETTLE;
    endcase
  end

  always_comb begin
    capture  = (state == SETTLE) && at_cap && $onehot(sel) && !clear;
    complete = (&seen) && !clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen        <= '0;
      slot_val    <= '0;
      slot_err    <= '0;
      value       <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else if (clear) begin
      seen        <= '0;
      slot_val    <= '0;
      slot_err    <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= complete;
      if (complete) begin
        value     <= slot_val;
        digit_err <= slot_err;
      end
      seen <= (complete ? '0 : seen) | (capture ? sel : '0);
      for (int i = 0; i < DIGITS; i++) begin
        if (capture && sel[i]) begin
          slot_val[4*i +: 4] <= dec[3:0];
          slot_err[i]        <= dec[4];
        end
      end
    end
  end

endmodule
